// File: rtl/spi_flash_master_if.sv
// Command, write-data and read-data handshake between host logic and spi_flash_master.
// The host drives the master modport; the SPI engine takes the slave modport.
interface spi_flash_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic        cmd_has_addr;
    logic [23:0] cmd_addr;
    logic        cmd_dummy;
    logic        cmd_write;
    logic [15:0] cmd_len;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_strobe;
    logic        done;
    logic        busy;

    modport master (
        output cmd_valid, cmd_opcode, cmd_has_addr, cmd_addr, cmd_dummy, cmd_write, cmd_len,
               tx_data, tx_valid,
        input  cmd_ready, tx_ready, rx_data, rx_strobe, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_has_addr, cmd_addr, cmd_dummy, cmd_write, cmd_len,
               tx_data, tx_valid,
        output cmd_ready, tx_ready, rx_data, rx_strobe, done, busy
    );
endinterface

// File: rtl/spi_flash_master.sv
// SPI mode-0 initiator for JEDEC serial-flash commands: opcode, optional 24-bit address,
// optional dummy byte, then 0..65535 data bytes in or out; one command per handshake.
module spi_flash_master #(
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned CS_IDLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    spi_flash_master_if.slave bus,
    output logic              spi_cs,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_IDLE_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle, StSetup, StOpcode, StAddr, StDummy, StData, StTxWait, StHold, StGap
    } state_e;

    state_e           state_q, state_d, next_st;
    logic [DIV_W-1:0] div_q, div_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [2:0]       bit_q, bit_d;
    logic             cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;
    logic [7:0]       tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
    logic             rx_strobe_q, rx_strobe_d, done_q, done_d;
    logic [23:0]      addr_q, addr_d;
    logic             has_addr_q, has_addr_d, dummy_q, dummy_d, write_q, write_d;
    logic [15:0]      len_q, len_d;
    logic [1:0]       addr_idx_q, addr_idx_d;
    logic             ready_en_q, miso_s1_q, miso_s2_q;
    logic             div_end, byte_end, tx_take;

    assign div_end = (div_q == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            div_q       <= '0;
            gap_q       <= '0;
            bit_q       <= 3'd0;
            cs_q        <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            tx_sr_q     <= 8'h00;
            rx_sr_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_strobe_q <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= 24'h0;
            has_addr_q  <= 1'b0;
            dummy_q     <= 1'b0;
            write_q     <= 1'b0;
            len_q       <= 16'h0;
            addr_idx_q  <= 2'd0;
            ready_en_q  <= 1'b0;
            miso_s1_q   <= 1'b0;
            miso_s2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            bit_q       <= bit_d;
            cs_q        <= cs_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_strobe_q <= rx_strobe_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            has_addr_q  <= has_addr_d;
            dummy_q     <= dummy_d;
            write_q     <= write_d;
            len_q       <= len_d;
            addr_idx_q  <= addr_idx_d;
            ready_en_q  <= 1'b1;
            miso_s1_q   <= spi_miso;
            miso_s2_q   <= miso_s1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        next_st     = StHold;
        div_d       = div_q;
        gap_d       = gap_q;
        bit_d       = bit_q;
        cs_d        = cs_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_data_d   = rx_data_q;
        rx_strobe_d = 1'b0;
        done_d      = 1'b0;
        addr_d      = addr_q;
        has_addr_d  = has_addr_q;
        dummy_d     = dummy_q;
        write_d     = write_q;
        len_d       = len_q;
        addr_idx_d  = addr_idx_q;
        byte_end    = 1'b0;
        tx_take     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ready_en_q && bus.cmd_valid) begin
                    state_d    = StSetup;
                    cs_d       = 1'b0;
                    div_d      = '0;
                    tx_sr_d    = bus.cmd_opcode;
                    addr_d     = bus.cmd_addr;
                    has_addr_d = bus.cmd_has_addr;
                    dummy_d    = bus.cmd_dummy;
                    write_d    = bus.cmd_write;
                    len_d      = bus.cmd_len;
                end
            end
            StSetup: begin
                if (div_end) begin
                    state_d = StOpcode;
                    div_d   = '0;
                    bit_d   = 3'd0;
                    mosi_d  = tx_sr_q[7];
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StOpcode, StAddr, StDummy, StData: begin
                if (!div_end) begin
                    div_d = div_q + DIV_W'(1);
                end else if (!sck_q) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    rx_sr_d = {rx_sr_q[6:0], miso_s2_q};
                    if (state_q == StData && !write_q && bit_q == 3'd7) begin
                        rx_data_d   = {rx_sr_q[6:0], miso_s2_q};
                        rx_strobe_d = 1'b1;
                    end
                end else begin
                    div_d = '0;
                    sck_d = 1'b0;
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        mosi_d  = tx_sr_q[6];
                    end else begin
                        bit_d    = 3'd0;
                        byte_end = 1'b1;
                    end
                end
            end
            StTxWait: begin
                // SCK stays low and CS stays asserted until the host supplies the byte
                if (bus.tx_valid) begin
                    tx_take = 1'b1;
                    tx_sr_d = bus.tx_data;
                    mosi_d  = bus.tx_data[7];
                    div_d   = '0;
                    state_d = StData;
                end
            end
            StHold: begin
                if (div_end) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StGap: begin
                if (gap_q == GAP_LAST) state_d = StIdle;
                else                   gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = StIdle;
        endcase

        // Pick the next byte once the 8th falling SCK edge of the current one is issued
        if (byte_end) begin
            if (state_q == StOpcode && has_addr_q) begin
                next_st    = StAddr;
                addr_idx_d = 2'd2;
            end else if (state_q == StAddr && addr_idx_q != 2'd0) begin
                next_st    = StAddr;
                addr_idx_d = addr_idx_q - 2'd1;
            end else if (state_q == StData) begin
                len_d = len_q - 16'd1;
                if (len_q != 16'd1) next_st = StData;
            end else if (state_q != StDummy && dummy_q) begin
                next_st = StDummy;
            end else if (len_q != 16'd0) begin
                next_st = StData;
            end
            state_d = next_st;
            tx_sr_d = 8'h00;
            if (next_st == StAddr) begin
                case (addr_idx_d)
                    2'd2:    tx_sr_d = addr_q[23:16];
                    2'd1:    tx_sr_d = addr_q[15:8];
                    default: tx_sr_d = addr_q[7:0];
                endcase
            end else if (next_st == StData && write_q) begin
                if (bus.tx_valid) begin
                    tx_take = 1'b1;
                    tx_sr_d = bus.tx_data;
                end else begin
                    state_d = StTxWait;
                end
            end
            mosi_d = tx_sr_d[7];
        end
    end

    assign bus.cmd_ready = (state_q == StIdle) && ready_en_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.tx_ready  = tx_take;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_strobe = rx_strobe_q;
    assign bus.done      = done_q;
    assign spi_cs        = cs_q;
    assign spi_sck       = sck_q;
    assign spi_mosi      = mosi_q;
endmodule

// File: tb/tb_spi_flash_master.sv
// Directed bench for spi_flash_master: a small flash emulator answers on MISO and records MOSI,
// and each step compares against hand-computed values.
module tb_spi_flash_master;
    logic clk = 1'b0;
    logic reset;
    logic spi_cs, spi_sck, spi_mosi, spi_miso;

    spi_flash_master_if bus ();

    spi_flash_master #(.CLK_DIV(2), .CS_IDLE_CYCLES(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .spi_cs   (spi_cs),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    int n_pass, n_total;

    // Flash emulator: captures MOSI on SCK rise and presents the next MISO bit right away.
    int          em_bits, em_last_bits;
    logic [7:0]  em_sr, em_op;
    logic [23:0] em_addr;
    logic [7:0]  mosi_q[$];

    function automatic logic [7:0] em_image(input logic [23:0] a);
        case (a)
            24'h123456: return 8'hAA;
            24'h123457: return 8'hBB;
            24'h123458: return 8'hCC;
            24'h123459: return 8'hDD;
            24'h000100: return 8'h5A;
            default:    return a[7:0] ^ 8'h3C;
        endcase
    endfunction

    function automatic logic em_bit(input int p);
        int         start;
        logic [7:0] b;
        case (em_op)
            8'h9F:   start = 8;
            8'h03:   start = 32;
            8'h0B:   start = 40;
            default: return 1'b0;
        endcase
        if (p < start) return 1'b0;
        if (em_op == 8'h9F) begin
            case ((p - start) / 8)
                0:       b = 8'hC2;
                1:       b = 8'h20;
                default: b = 8'h18;
            endcase
        end else begin
            b = em_image(em_addr + 24'((p - start) / 8));
        end
        return b[7 - ((p - start) % 8)];
    endfunction

    always @(posedge spi_sck or posedge spi_cs) begin
        if (spi_cs) begin
            em_last_bits = em_bits;
            em_bits      = 0;
            spi_miso     = 1'b0;
        end else begin
            em_sr   = {em_sr[6:0], spi_mosi};
            em_bits = em_bits + 1;
            if (em_bits % 8 == 0) begin
                mosi_q.push_back(em_sr);
                if (em_bits == 8)       em_op   = em_sr;
                else if (em_bits <= 32) em_addr = {em_addr[15:0], em_sr};
            end
            spi_miso = em_bit(em_bits);
        end
    end

    int         cs_low_cnt, gap_cnt, done_cnt, tx_cnt;
    logic [7:0] rx_q[$];
    int         rx_bits_q[$];

    always @(negedge clk) begin
        if (!spi_cs) cs_low_cnt++;
        if (spi_cs && bus.busy) gap_cnt++;
        if (bus.done) done_cnt++;
        if (bus.tx_ready) tx_cnt++;
        if (bus.rx_strobe) begin
            rx_q.push_back(bus.rx_data);
            rx_bits_q.push_back(em_bits);
        end
    end

    int b_cs, b_gap, b_done, b_tx, b_rx, b_mo;

    task automatic snap();
        b_cs = cs_low_cnt; b_gap = gap_cnt; b_done = done_cnt; b_tx = tx_cnt;
        b_rx = rx_q.size(); b_mo = mosi_q.size();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [7:0] op, input logic ha, input logic [23:0] a,
                         input logic dm, input logic wr, input logic [15:0] len);
        int t = 0;
        while (!bus.cmd_ready && t < 300) begin @(negedge clk); t++; end
        chk("cmd_ready_before_issue", bus.cmd_ready, 1);
        bus.cmd_opcode = op; bus.cmd_has_addr = ha; bus.cmd_addr = a;
        bus.cmd_dummy = dm; bus.cmd_write = wr; bus.cmd_len = len; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = 8'hFF; bus.cmd_addr = 24'hFFFFFF;
        bus.cmd_len = 16'hFFFF; bus.cmd_has_addr = 1'b0; bus.cmd_dummy = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        while (!bus.cmd_ready && t < budget) begin @(negedge clk); t++; end
        chk(tag, bus.cmd_ready, 1);
    endtask

    task automatic wait_tx(input string tag, input int budget);
        int t = 0;
        while (!bus.tx_ready && t < budget) begin @(negedge clk); t++; end
        chk(tag, bus.tx_ready, 1);
    endtask

    initial begin
        int         t;
        logic [7:0] exp4[4];
        n_pass = 0; n_total = 0;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = 8'h00; bus.cmd_has_addr = 1'b0;
        bus.cmd_addr = 24'h0; bus.cmd_dummy = 1'b0; bus.cmd_write = 1'b0; bus.cmd_len = 16'h0;
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs", spi_cs, 1);
        chk("rst_sck", spi_sck, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rx_strobe", bus.rx_strobe, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_tx_ready", bus.tx_ready, 0);
        reset = 1'b0;
        #1 chk("ready_before_first_clk", bus.cmd_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_first_clk", bus.cmd_ready, 1);

        // WREN
        snap();
        issue(8'h06, 1'b0, 24'h0, 1'b0, 1'b0, 16'd0);
        wait_idle("wren_complete", 500);
        chk("wren_sck_pulses", em_last_bits, 8);
        chk("wren_mosi", mosi_q[b_mo], 8'h06);
        chk("wren_cs_low_clk", cs_low_cnt - b_cs, 36);
        chk("wren_done", done_cnt - b_done, 1);
        chk("wren_gap_clk", gap_cnt - b_gap, 8);
        chk("wren_no_rx", rx_q.size() - b_rx, 0);

        // RDID
        snap();
        issue(8'h9F, 1'b0, 24'h0, 1'b0, 1'b0, 16'd3);
        wait_idle("rdid_complete", 1000);
        chk("rdid_rx_count", rx_q.size() - b_rx, 3);
        chk("rdid_rx0", rx_q[b_rx], 8'hC2);
        chk("rdid_rx1", rx_q[b_rx + 1], 8'h20);
        chk("rdid_rx2", rx_q[b_rx + 2], 8'h18);
        chk("rdid_done", done_cnt - b_done, 1);
        chk("rdid_busy_low", bus.busy, 0);

        // READ 0x123456, 4 bytes
        snap();
        issue(8'h03, 1'b1, 24'h123456, 1'b0, 1'b0, 16'd4);
        wait_idle("read_complete", 2000);
        exp4 = '{8'h03, 8'h12, 8'h34, 8'h56};
        for (int i = 0; i < 4; i++) chk($sformatf("read_mosi%0d", i), mosi_q[b_mo + i], exp4[i]);
        chk("read_mosi_bytes", mosi_q.size() - b_mo, 8);
        chk("read_mosi_data_zero", mosi_q[b_mo + 5], 8'h00);
        exp4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) chk($sformatf("read_rx%0d", i), rx_q[b_rx + i], exp4[i]);
        chk("read_rx_count", rx_q.size() - b_rx, 4);

        // FASTREAD 0x000100 with dummy byte, 2 bytes
        snap();
        issue(8'h0B, 1'b1, 24'h000100, 1'b1, 1'b0, 16'd2);
        wait_idle("fast_complete", 2000);
        chk("fast_sck_total", em_last_bits, 56);
        chk("fast_first_rx_at_rise", rx_bits_q[b_rx], 48);
        chk("fast_rx0", rx_q[b_rx], 8'h5A);
        chk("fast_rx1", rx_q[b_rx + 1], 8'h3D);
        chk("fast_mosi_op", mosi_q[b_mo], 8'h0B);
        chk("fast_mosi_addr_mid", mosi_q[b_mo + 2], 8'h01);
        chk("fast_mosi_dummy", mosi_q[b_mo + 4], 8'h00);

        // PP with a 50-clk tx stall before the second byte
        snap();
        bus.tx_data = 8'h11; bus.tx_valid = 1'b1;
        issue(8'h02, 1'b1, 24'h000010, 1'b0, 1'b1, 16'd3);
        wait_tx("pp_tx0_ready", 1000);
        @(posedge clk); #1 bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
        repeat (50) @(negedge clk);
        chk("pp_stall_bits", em_bits, 40);
        chk("pp_stall_sck_low", spi_sck, 0);
        chk("pp_stall_cs_low", spi_cs, 0);
        chk("pp_stall_tx_count", tx_cnt - b_tx, 1);
        bus.tx_data = 8'h22; bus.tx_valid = 1'b1;
        #1 wait_tx("pp_tx1_ready", 100);
        @(posedge clk); #1 bus.tx_data = 8'h33;
        wait_tx("pp_tx2_ready", 200);
        @(posedge clk); #1 bus.tx_valid = 1'b0;
        wait_idle("pp_complete", 1000);
        chk("pp_byte0", mosi_q[b_mo + 4], 8'h11);
        chk("pp_byte1", mosi_q[b_mo + 5], 8'h22);
        chk("pp_byte2", mosi_q[b_mo + 6], 8'h33);
        chk("pp_sck_total", em_last_bits, 56);
        chk("pp_tx_count", tx_cnt - b_tx, 3);
        chk("pp_done", done_cnt - b_done, 1);

        // Reset in the middle of the address phase
        snap();
        issue(8'h03, 1'b1, 24'hABCDEF, 1'b0, 1'b0, 16'd2);
        t = 0;
        while (em_bits < 12 && t < 1000) begin @(negedge clk); t++; end
        chk("rstmid_in_addr", em_bits, 12);
        reset = 1'b1;
        #1;
        chk("rstmid_cs_high", spi_cs, 1);
        chk("rstmid_sck_low", spi_sck, 0);
        chk("rstmid_busy_low", bus.busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_no_done", done_cnt - b_done, 0);
        chk("rstmid_no_rx", rx_q.size() - b_rx, 0);

        snap();
        issue(8'h9F, 1'b0, 24'h0, 1'b0, 1'b0, 16'd3);
        wait_idle("rdid2_complete", 1000);
        chk("rdid2_rx0", rx_q[b_rx], 8'hC2);
        chk("rdid2_rx1", rx_q[b_rx + 1], 8'h20);
        chk("rdid2_rx2", rx_q[b_rx + 2], 8'h18);
        chk("rdid2_done", done_cnt - b_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
